// File: rtl/negate_seq_if.sv
// negate_seq_if: request/result bundle between the control unit and the sign unit
interface negate_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             overflow;
    logic             zero;

    modport master (
        output start, mode, a,
        input  result, busy, done, overflow, zero
    );

    modport slave (
        input  start, mode, a,
        output result, busy, done, overflow, zero
    );
endinterface

// File: rtl/negate_seq.sv
// negate_seq: multi-cycle pass/negate/abs unit, CHUNK bits of the +1 carry chain per cycle
module negate_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic        clock,
    input logic        clear,
    negate_seq_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             inv_q, inv_d;
    logic             carry_q, carry_d;
    logic             ov_q, ov_d;
    logic             zero_q, zero_d;
    logic             accept;
    logic             last;
    logic [CHUNK-1:0] chunk;
    logic [CHUNK:0]   sum;

    // Next state: accept a request outside RUN, otherwise ripple one chunk per cycle
    always_comb begin
        accept  = bus.start && state_q != RUN;
        last    = idx_q == IW'(NCH - 1);
        chunk   = op_q[int'(idx_q) * CHUNK +: CHUNK];
        sum     = {1'b0, chunk ^ {CHUNK{inv_q}}} + {{CHUNK{1'b0}}, carry_q};
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        idx_d   = idx_q;
        inv_d   = inv_q;
        carry_d = carry_q;
        ov_d    = ov_q;
        zero_d  = zero_q;
        if (accept) begin
            op_d    = bus.a;
            inv_d   = bus.mode == 2'b01 || (bus.mode == 2'b10 && bus.a[WIDTH-1]);
            carry_d = inv_d;
            idx_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            res_d[int'(idx_q) * CHUNK +: CHUNK] = sum[CHUNK-1:0];
            carry_d = sum[CHUNK];
            idx_d   = idx_q + 1'b1;
            if (last) begin
                state_d = DONE;
                idx_d   = '0;
                carry_d = 1'b0;
                ov_d    = inv_q && op_q == MIN_NEG;
                zero_d  = res_d == '0;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; clear aborts any computation at once
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            op_q    <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            inv_q   <= 1'b0;
            carry_q <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            inv_q   <= inv_d;
            carry_q <= carry_d;
            ov_q    <= ov_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.result   = res_q;
    assign bus.busy     = state_q == RUN;
    assign bus.done     = state_q == DONE;
    assign bus.overflow = ov_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_negate_seq.sv
// tb_negate_seq: vector table over three chunk sizes plus handshake and clear sequences
module tb_negate_seq;
    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    negate_seq_if #(.WIDTH(32)) i8 ();
    negate_seq_if #(.WIDTH(32)) i32 ();
    negate_seq_if #(.WIDTH(32)) i1 ();

    negate_seq #(.WIDTH(32), .CHUNK(8))  u8  (.clock(clock), .clear(clear), .bus(i8));
    negate_seq #(.WIDTH(32), .CHUNK(32)) u32 (.clock(clock), .clear(clear), .bus(i32));
    negate_seq #(.WIDTH(32), .CHUNK(1))  u1  (.clock(clock), .clear(clear), .bus(i1));

    logic [2:0]  dn, ovw, zw;
    logic [31:0] rs [3];
    assign dn     = {i1.done, i32.done, i8.done};
    assign ovw    = {i1.overflow, i32.overflow, i8.overflow};
    assign zw     = {i1.zero, i32.zero, i8.zero};
    assign rs[0]  = i8.result;
    assign rs[1]  = i32.result;
    assign rs[2]  = i1.result;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] res;
        logic        ov;
        logic        z;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic s, input logic [1:0] m, input logic [31:0] v);
        if (sel[0]) begin i8.start = s;  i8.mode = m;  i8.a = v;  end
        if (sel[1]) begin i32.start = s; i32.mode = m; i32.a = v; end
        if (sel[2]) begin i1.start = s;  i1.mode = m;  i1.a = v;  end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [10];
        int          nch [3];
        int          lat [3];
        logic [31:0] rr [3];
        logic        ro [3];
        logic        rz [3];
        logic        seen;
        nch = '{4, 1, 32};
        tbl[0] = '{2'b01, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 1'b0};
        tbl[1] = '{2'b10, 32'hFFFF_FFF6, 32'h0000_000A, 1'b0, 1'b0};
        tbl[2] = '{2'b10, 32'h0000_000A, 32'h0000_000A, 1'b0, 1'b0};
        tbl[3] = '{2'b01, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[4] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0};
        tbl[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
        tbl[6] = '{2'b11, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0};
        tbl[7] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0};
        tbl[8] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[9] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
        drive(3'b111, 1'b0, 2'b00, 32'h0);
        repeat (3) step;
        chk("rst_result", i8.result, 32'h0);
        chk("rst_busy", 32'(i8.busy), 32'h0);
        chk("rst_done", 32'(i8.done), 32'h0);
        chk("rst_overflow", 32'(i8.overflow), 32'h0);
        chk("rst_zero", 32'(i8.zero), 32'h0);
        #3 clear = 1'b0;
        step;
        for (int v = 0; v < 10; v++) begin
            drive(3'b111, 1'b1, tbl[v].mode, tbl[v].a);
            step;
            drive(3'b111, 1'b0, 2'b01, 32'hDEAD_BEEF);
            lat = '{0, 0, 0};
            for (int c = 1; c <= 40 && !(lat[0] != 0 && lat[1] != 0 && lat[2] != 0); c++) begin
                step;
                for (int k = 0; k < 3; k++)
                    if (lat[k] == 0 && dn[k]) begin
                        lat[k] = c;
                        rr[k]  = rs[k];
                        ro[k]  = ovw[k];
                        rz[k]  = zw[k];
                    end
            end
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("v%0d_u%0d_latency", v, k), 32'(lat[k]), 32'(nch[k]));
                chk($sformatf("v%0d_u%0d_result", v, k), rr[k], tbl[v].res);
                chk($sformatf("v%0d_u%0d_overflow", v, k), 32'(ro[k]), 32'(tbl[v].ov));
                chk($sformatf("v%0d_u%0d_zero", v, k), 32'(rz[k]), 32'(tbl[v].z));
            end
            step;
        end
        drive(3'b001, 1'b1, 2'b01, 32'h1);
        step;
        chk("ign_busy_e0", 32'(i8.busy), 32'h1);
        for (int c = 1; c <= 3; c++) begin
            drive(3'b001, 1'b1, 2'b01, 32'h7);
            step;
            chk($sformatf("ign_busy_c%0d", c), 32'(i8.busy), 32'h1);
            chk($sformatf("ign_done_c%0d", c), 32'(i8.done), 32'h0);
        end
        drive(3'b001, 1'b0, 2'b01, 32'h7);
        step;
        chk("ign_done", 32'(i8.done), 32'h1);
        chk("ign_busy_low", 32'(i8.busy), 32'h0);
        chk("ign_result", i8.result, 32'hFFFF_FFFF);
        drive(3'b001, 1'b1, 2'b01, 32'h2);
        step;
        chk("b2b_busy", 32'(i8.busy), 32'h1);
        chk("b2b_done_low", 32'(i8.done), 32'h0);
        drive(3'b001, 1'b0, 2'b00, 32'h0);
        repeat (3) step;
        chk("b2b_not_yet", 32'(i8.done), 32'h0);
        step;
        chk("b2b_done", 32'(i8.done), 32'h1);
        chk("b2b_result", i8.result, 32'hFFFF_FFFE);
        step;
        chk("b2b_done_pulse", 32'(i8.done), 32'h0);
        chk("b2b_idle_busy", 32'(i8.busy), 32'h0);
        chk("b2b_result_held", i8.result, 32'hFFFF_FFFE);
        drive(3'b001, 1'b1, 2'b01, 32'h5);
        step;
        drive(3'b001, 1'b0, 2'b00, 32'h0);
        step;
        step;
        #3 clear = 1'b1;
        #1;
        chk("clr_busy", 32'(i8.busy), 32'h0);
        chk("clr_result", i8.result, 32'h0);
        chk("clr_done", 32'(i8.done), 32'h0);
        #2 clear = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            step;
            if (i8.done || i8.busy) seen = 1'b1;
        end
        chk("clr_no_done", 32'(seen), 32'h0);
        drive(3'b001, 1'b1, 2'b10, 32'hFFFF_FFF6);
        step;
        drive(3'b001, 1'b0, 2'b00, 32'h0);
        repeat (4) step;
        chk("clr_fresh_done", 32'(i8.done), 32'h1);
        chk("clr_fresh_result", i8.result, 32'h0000_000A);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
